// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//
// Bridges a simple cache-side read/write request interface onto an AXI3-style
// master. Reads and writes run in two independent FSMs so that one read and
// one write can be in flight at the same time. A read that targets the same
// 16-byte line as an outstanding (or same-cycle) write is held off until the
// write response has been received, which keeps read-after-write ordering.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   rd_req/rd_type/rd_addr     cache read request; rd_rdy = accepted this cycle
//   ret_valid/ret_last/ret_data read return beats (pass-through of R channel)
//   wr_req/wr_type/wr_addr     cache write request with wr_wstrb / wr_data
//   wr_rdy, data_write_ok      write accepted; one-cycle pulse on B response
//   ar*/r*                     AXI read address / read data channels
//   aw*/w*/b*                  AXI write address / write data / response
//
// Request type encoding: 0 byte, 1 half, 2 word, 4 full 16-byte line.

module cache_axi_bridge #(
  parameter logic [3:0] AXI_RID = 4'd0,
  parameter logic [3:0] AXI_WID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  // cache read side
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  // cache write side
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         data_write_ok,
  // AXI read address
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI write address
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  r_state_e       r_state_q, r_state_d;
  logic [31:0]    r_addr_q, r_addr_d;
  logic [2:0]     r_type_q, r_type_d;

  w_state_e       w_state_q, w_state_d;
  logic [1:0]     w_cnt_q, w_cnt_d;
  logic [31:0]    w_addr_q, w_addr_d;
  logic [2:0]     w_type_q, w_type_d;
  logic [3:0]     w_strb_q, w_strb_d;
  logic [127:0]   w_data_q, w_data_d;

  logic rd_accept, wr_accept, hazard;
  logic r_line, w_line;

  // IDs and response codes are not checked: the bridge only ever has one
  // transaction per direction outstanding.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp};

  assign wr_rdy    = (w_state_q == W_IDLE);
  assign wr_accept = wr_req && wr_rdy;

  // A read may not overtake a write to the same line: compare against the
  // write still in flight and against a write being accepted this very cycle.
  assign hazard = ((w_state_q != W_IDLE) && (rd_addr[31:4] == w_addr_q[31:4])) ||
                  (wr_accept && (rd_addr[31:4] == wr_addr[31:4]));

  assign rd_rdy    = (r_state_q == R_IDLE) && !hazard;
  assign rd_accept = rd_req && rd_rdy;

  assign r_line = (r_type_q == 3'd4);
  assign w_line = (w_type_q == 3'd4);

  // Read channel outputs are decoded from the held request; line requests
  // become 4-beat word bursts aligned to the line base.
  assign arid      = AXI_RID;
  assign araddr    = r_line ? {r_addr_q[31:4], 4'h0} : r_addr_q;
  assign arlen     = r_line ? 8'd3 : 8'd0;
  assign arsize    = r_line ? 3'd2 : {1'b0, r_type_q[1:0]};
  assign arburst   = 2'b01;
  assign arvalid   = (r_state_q == R_ADDR);
  assign rready    = (r_state_q == R_DATA);
  assign ret_valid = (r_state_q == R_DATA) && rvalid;
  assign ret_last  = (r_state_q == R_DATA) && rlast;
  assign ret_data  = rdata;

  assign awid    = AXI_WID;
  assign awaddr  = w_line ? {w_addr_q[31:4], 4'h0} : w_addr_q;
  assign awlen   = w_line ? 8'd3 : 8'd0;
  assign awsize  = w_line ? 3'd2 : {1'b0, w_type_q[1:0]};
  assign awburst = 2'b01;
  assign awvalid = (w_state_q == W_ADDR);

  // The beat counter selects the word of the held line; wlast compares it to
  // the low bits of the burst length.
  assign wid    = AXI_WID;
  assign wdata  = w_data_q[{w_cnt_q, 5'b0} +: 32];
  assign wlast  = (w_cnt_q == (w_line ? 2'd3 : 2'd0));
  assign wstrb  = w_line ? 4'hF : w_strb_q;
  assign wvalid = (w_state_q == W_DATA);
  assign bready = (w_state_q == W_RESP);

  assign data_write_ok = (w_state_q == W_RESP) && bvalid;

  // Read FSM next state; request fields are captured only on accept.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_type_d  = r_type_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_accept) begin
          r_state_d = R_ADDR;
          r_addr_d  = rd_addr;
          r_type_d  = rd_type;
        end
      end
      R_ADDR: if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid && rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state; the counter is cleared on the way into W_DATA.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_addr_d  = w_addr_q;
    w_type_d  = w_type_q;
    w_strb_d  = w_strb_q;
    w_data_d  = w_data_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          w_state_d = W_ADDR;
          w_addr_d  = wr_addr;
          w_type_d  = wr_type;
          w_strb_d  = wr_wstrb;
          w_data_d  = wr_data;
        end
      end
      W_ADDR: begin
        if (awready) begin
          w_state_d = W_DATA;
          w_cnt_d   = 2'd0;
        end
      end
      W_DATA: begin
        if (wready) begin
          w_cnt_d = w_cnt_q + 2'd1;
          if (wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'd0;
      r_type_q  <= 3'd0;
      w_state_q <= W_IDLE;
      w_cnt_q   <= 2'd0;
      w_addr_q  <= 32'd0;
      w_type_q  <= 3'd0;
      w_strb_q  <= 4'd0;
      w_data_q  <= 128'd0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_type_q  <= r_type_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_addr_q  <= w_addr_d;
      w_type_q  <= w_type_d;
      w_strb_q  <= w_strb_d;
      w_data_q  <= w_data_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Testbench for cache_axi_bridge. The bench plays the cache and an AXI slave
// with random stalls; expected AXI fields and beats come from the request
// rules (line -> 4 word beats at the aligned base, otherwise a single beat).

module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req, wr_req;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         rd_rdy, ret_valid, ret_last, wr_rdy, data_write_ok;
  logic [31:0]  ret_data;
  logic [3:0]   arid, awid, wid, rid, bid, wstrb;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .data_write_ok(data_write_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Reference rules for what a request should look like on AXI.
  function automatic logic [31:0] exp_addr(input logic [2:0] t, input logic [31:0] a);
    return (t == 3'd4) ? (a & 32'hFFFF_FFF0) : a;
  endfunction

  function automatic int exp_beats(input logic [2:0] t);
    return (t == 3'd4) ? 4 : 1;
  endfunction

  function automatic logic [2:0] exp_size(input logic [2:0] t);
    return (t == 3'd4) ? 3'd2 : (t % 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_phase(input logic [2:0] t, input logic [31:0] a);
    int k = $urandom_range(0, 3);
    arready = 1'b0;
    for (int i = 0; i < k; i++) begin
      #1 checkOutput("arvalid_hold", arvalid, 1);
      cyc();
    end
    arready = 1'b1;
    #1;
    checkOutput("arvalid", arvalid, 1);
    checkOutput("araddr", araddr, exp_addr(t, a));
    checkOutput("arlen", arlen, exp_beats(t) - 1);
    checkOutput("arsize", arsize, exp_size(t));
    checkOutput("arburst", arburst, 1);
    checkOutput("arid", arid, 0);
    cyc();
    arready = 1'b0;
  endtask

  task automatic r_phase(input int beats);
    for (int b = 0; b < beats; b++) begin
      int k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        rvalid = 1'b0;
        #1 checkOutput("ret_valid_idle", ret_valid, 0);
        checkOutput("rready", rready, 1);
        cyc();
      end
      rvalid = 1'b1;
      rdata  = $urandom;
      rlast  = (b == beats - 1);
      #1;
      checkOutput("ret_valid", ret_valid, 1);
      checkOutput("ret_data", ret_data, rdata);
      checkOutput("ret_last", ret_last, (b == beats - 1) ? 1 : 0);
      cyc();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1 checkOutput("rready_done", rready, 0);
    checkOutput("rd_rdy_done", rd_rdy, 1);
  endtask

  task automatic aw_phase(input logic [2:0] t, input logic [31:0] a);
    int k = $urandom_range(0, 3);
    awready = 1'b0;
    for (int i = 0; i < k; i++) begin
      #1 checkOutput("awvalid_hold", awvalid, 1);
      cyc();
    end
    awready = 1'b1;
    #1;
    checkOutput("awvalid", awvalid, 1);
    checkOutput("awaddr", awaddr, exp_addr(t, a));
    checkOutput("awlen", awlen, exp_beats(t) - 1);
    checkOutput("awsize", awsize, exp_size(t));
    checkOutput("awburst", awburst, 1);
    checkOutput("awid", awid, 1);
    cyc();
    awready = 1'b0;
  endtask

  // mode 1 toggles wready every cycle starting low; mode 0 is random.
  task automatic w_phase(input logic [2:0] t, input logic [3:0] strb,
                         input logic [127:0] data, input int mode);
    int beats  = exp_beats(t);
    int idx    = 0;
    int budget = 0;
    logic tog  = 1'b0;
    while (idx < beats && budget < 64) begin
      wready = (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1;
      checkOutput("wvalid", wvalid, 1);
      checkOutput("wdata", wdata, data[32*idx +: 32]);
      checkOutput("wstrb", wstrb, (t == 3'd4) ? 4'hF : strb);
      checkOutput("wlast", wlast, (idx == beats - 1) ? 1 : 0);
      checkOutput("wid", wid, 1);
      cyc();
      if (wready) idx++;
      budget++;
    end
    wready = 1'b0;
    if (idx < beats) checkOutput("w_budget", idx, beats);
    #1 checkOutput("wvalid_done", wvalid, 0);
  endtask

  task automatic b_phase();
    int k = $urandom_range(0, 3);
    bvalid = 1'b0;
    for (int i = 0; i < k; i++) begin
      #1 checkOutput("bready", bready, 1);
      checkOutput("write_ok_early", data_write_ok, 0);
      cyc();
    end
    bvalid = 1'b1;
    #1 checkOutput("write_ok", data_write_ok, 1);
    cyc();
    bvalid = 1'b0;
    #1 checkOutput("write_ok_pulse", data_write_ok, 0);
    checkOutput("bready_done", bready, 0);
    checkOutput("wr_rdy_done", wr_rdy, 1);
  endtask

  // One complete read or write transaction through the bridge.
  task automatic applyStimulus(input bit is_write, input logic [2:0] t, input logic [31:0] a,
                               input logic [3:0] strb, input logic [127:0] data, input int mode);
    if (!is_write) begin
      rd_req = 1'b1; rd_type = t; rd_addr = a;
      #1 checkOutput("rd_rdy_accept", rd_rdy, 1);
      cyc();
      rd_req = 1'b0;
      #1 checkOutput("rd_rdy_busy", rd_rdy, 0);
      ar_phase(t, a);
      r_phase(exp_beats(t));
    end else begin
      wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = strb; wr_data = data;
      #1 checkOutput("wr_rdy_accept", wr_rdy, 1);
      cyc();
      wr_req = 1'b0;
      #1 checkOutput("wr_rdy_busy", wr_rdy, 0);
      aw_phase(t, a);
      w_phase(t, strb, data, mode);
      b_phase();
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    logic [2:0]   types [4];
    types = '{3'd0, 3'd1, 3'd2, 3'd4};

    reset = 1'b1;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_ret_valid", ret_valid, 0);
    checkOutput("rst_write_ok", data_write_ok, 0);
    checkOutput("rst_rd_rdy", rd_rdy, 1);
    checkOutput("rst_wr_rdy", wr_rdy, 1);
    reset = 1'b0;
    cyc();

    $display("[TB] line read");
    applyStimulus(0, 3'd4, 32'h1C00_0014, 4'h0, 128'd0, 0);

    $display("[TB] line write with toggling wready");
    applyStimulus(1, 3'd4, 32'h0000_1238, 4'h0,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1);

    $display("[TB] byte write");
    d = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1, 3'd0, 32'h8000_0003, 4'b1000, d, 0);

    $display("[TB] read-after-write hazard");
    d = {$urandom, $urandom, $urandom, $urandom};
    wr_req = 1; wr_type = 3'd2; wr_addr = 32'h100; wr_wstrb = 4'hF; wr_data = d;
    rd_req = 0; rd_type = 3'd2; rd_addr = 32'h104;
    #1 checkOutput("haz_same_cycle", rd_rdy, 0);
    checkOutput("haz_wr_rdy", wr_rdy, 1);
    cyc();
    wr_req = 0; rd_req = 1;
    #1 checkOutput("haz_pending_addr", rd_rdy, 0);
    aw_phase(3'd2, 32'h100);
    #1 checkOutput("haz_pending_data", rd_rdy, 0);
    w_phase(3'd2, 4'hF, d, 0);
    checkOutput("haz_pending_resp", rd_rdy, 0);
    checkOutput("haz_no_ar", arvalid, 0);
    rd_addr = 32'h200;
    #1 checkOutput("other_line_rdy", rd_rdy, 1);
    cyc();
    rd_req = 0;
    ar_phase(3'd2, 32'h200);
    r_phase(1);
    rd_req = 1; rd_addr = 32'h104;
    #1 checkOutput("haz_still", rd_rdy, 0);
    bvalid = 1;
    #1 checkOutput("haz_b_cycle", rd_rdy, 0);
    checkOutput("haz_write_ok", data_write_ok, 1);
    cyc();
    bvalid = 0;
    #1 checkOutput("haz_released", rd_rdy, 1);
    cyc();
    rd_req = 0;
    ar_phase(3'd2, 32'h104);
    r_phase(1);

    $display("[TB] simultaneous read and write");
    d = {$urandom, $urandom, $urandom, $urandom};
    rd_req = 1; rd_type = 3'd4; rd_addr = 32'h3000_0044;
    wr_req = 1; wr_type = 3'd4; wr_addr = 32'h3000_0088; wr_data = d; wr_wstrb = 4'h3;
    #1 checkOutput("sim_rd_rdy", rd_rdy, 1);
    checkOutput("sim_wr_rdy", wr_rdy, 1);
    cyc();
    rd_req = 0; wr_req = 0;
    #1 checkOutput("sim_arvalid", arvalid, 1);
    checkOutput("sim_awvalid", awvalid, 1);
    ar_phase(3'd4, 32'h3000_0044);
    r_phase(4);
    aw_phase(3'd4, 32'h3000_0088);
    w_phase(3'd4, 4'h3, d, 0);
    b_phase();

    $display("[TB] reset during read beat 2");
    a = $urandom;
    rd_req = 1; rd_type = 3'd4; rd_addr = a;
    cyc();
    rd_req = 0;
    ar_phase(3'd4, a);
    rvalid = 1; rdata = $urandom; rlast = 0;
    #1 checkOutput("abort_beat1", ret_valid, 1);
    cyc();
    rdata = $urandom;
    reset = 1;
    #1 checkOutput("abort_rready", rready, 0);
    checkOutput("abort_rd_rdy", rd_rdy, 1);
    checkOutput("abort_ret_valid", ret_valid, 0);
    cyc();
    reset = 0;
    #1 checkOutput("abort_ret_valid2", ret_valid, 0);
    rvalid = 0;
    cyc();

    $display("[TB] reset during write data");
    d = {$urandom, $urandom, $urandom, $urandom};
    wr_req = 1; wr_type = 3'd4; wr_addr = 32'h5550; wr_data = d;
    cyc();
    wr_req = 0;
    aw_phase(3'd4, 32'h5550);
    wready = 1;
    cyc();
    wready = 0;
    reset = 1;
    #1 checkOutput("wabort_wvalid", wvalid, 0);
    checkOutput("wabort_wr_rdy", wr_rdy, 1);
    cyc();
    reset = 0;
    bvalid = 1;
    #1 checkOutput("wabort_no_ok", data_write_ok, 0);
    checkOutput("wabort_bready", bready, 0);
    cyc();
    bvalid = 0;

    $display("[TB] random transactions");
    for (int n = 0; n < 24; n++) begin
      logic [2:0] t;
      t = types[$urandom_range(0, 3)];
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), t, $urandom, 4'($urandom), d, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_RID, default 4'd0: fixed ARID for all reads.
REQ-002 SHALL have parameter AXI_WID, default 4'd1: fixed AWID and WID for all writes.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide these ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- rd_req  in  1  cache read request.
- rd_type  in  3  0 byte, 1 half, 2 word, 4 line.
- rd_addr  in  32  read address.
- rd_rdy  out  1  read request accepted this cycle.
- ret_valid  out  1  read beat valid.
- ret_last  out  1  final beat.
- ret_data  out  32  beat data.
- wr_req  in  1  cache write request.
- wr_type  in  3  encoding as rd_type.
- wr_addr  in  32  write address.
- wr_wstrb  in  4  byte strobe (single-beat only).
- wr_data  in  128  line data, word0 = [31:0].
- wr_rdy  out  1  write request accepted.
- data_write_ok  out  1  one-cycle pulse on write response.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1; arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1; awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready  in  1.
- bid/bresp/bvalid  in  4/2/1; bready  out  1.

Function
REQ-005 SHALL accept a read when rd_req && rd_rdy, and a write when wr_req && wr_rdy; both may be accepted in the same cycle.
REQ-006 SHALL implement read FSM R_IDLE -> R_ADDR (on read accept) -> R_DATA (on arvalid && arready) -> R_IDLE (on rvalid && rready && rlast).
REQ-007 SHALL implement write FSM W_IDLE -> W_ADDR (on accept) -> W_DATA (on awvalid && awready) -> W_RESP (on wvalid && wready && wlast) -> W_IDLE (on bvalid && bready).
REQ-008 SHALL register request address, type, strobe and data at accept and hold them stable until the FSM returns to idle.
REQ-009 SHALL derive len and size from the request type:
- type 4: len 3, size 2, address bits [3:0] forced to 0.
- otherwise: len 0, size = type[1:0], address unchanged.
- burst is INCR (2'b01).
REQ-010 SHALL drive arvalid only in R_ADDR, rready only in R_DATA, awvalid only in W_ADDR, wvalid only in W_DATA, bready only in W_RESP.
REQ-011 SHALL pass rvalid/rlast/rdata in R_DATA combinationally to ret_valid/ret_last/ret_data; ret_valid is 0 outside R_DATA.
REQ-012 SHALL use a 2-bit beat counter in W_DATA, reset to 0 on entering W_DATA and incremented on each wvalid && wready:
- wdata = registered data word [32*cnt+31 : 32*cnt].
- wlast = (cnt == len[1:0]).
- wstrb = 4'hF for line writes, otherwise registered wr_wstrb.
REQ-013 SHALL pulse data_write_ok for exactly one cycle on bvalid && bready; bresp and rresp are ignored.
REQ-014 SHALL define wr_rdy = (write state == W_IDLE).
REQ-015 SHALL define rd_rdy = (read state == R_IDLE) && !hazard, where hazard = rd_addr[31:4] equals the [31:4] of either:
- the pending write address, when write state != W_IDLE; or
- the same-cycle wr_addr, when wr_req && wr_rdy.
This blocks read-after-write to the same line until the B response completes.
REQ-016 SHALL tolerate ready/valid stalls of any length without dropping or duplicating beats; all valid outputs SHALL stay asserted until their handshake completes.

Reset
REQ-017 SHALL, while reset is high, force both FSMs idle, counter 0, and all valid/ready outputs 0 except rd_rdy/wr_rdy, which follow REQ-014/015.
REQ-018 SHALL abort any in-flight transaction on reset mid-operation; no data_write_ok or ret_valid SHALL be produced for the aborted transaction.

Verification
REQ-019 Line read: rd_req type 4, addr 0x1C00_0014 -> araddr 0x1C00_0010, arlen 3, arsize 2; 4 ret_valid beats, ret_last only on beat 4.
REQ-020 Line write: wr_data 0x4444_3333_2222_1111_... with wready toggling each cycle -> 4 W beats in word0..3 order, wlast on beat 4, one data_write_ok after bvalid.
REQ-021 Byte write: type 0, addr 0x...03, wstrb 4'b1000 -> awlen 0, awsize 0, a single beat with wlast = 1 and wstrb 4'b1000.
REQ-022 RAW hazard: a write to line 0x100 is pending and a read of 0x104 is requested -> rd_rdy stays 0 until the cycle after the B handshake; a read of 0x200 is accepted at once.
REQ-023 Simultaneous: rd_req and wr_req to different lines in the same cycle -> both accepted; arvalid and awvalid rise together on the next cycle.
REQ-024 Reset asserted during R_DATA beat 2 -> rready = 0 and rd_rdy = 1 immediately, with no further ret_valid.
